// File: rtl/data_mem_responder.sv
// Byte-addressed data memory for the core's load/store path: valid/ready request,
// configurable wait states, one-cycle response pulse and a combinational debug byte port.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 64,
    parameter int WAIT_STATES = 1,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [63:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [63:0]   req_wdata,
    output logic          resp_valid,
    output logic [63:0]   resp_rdata,
    output logic          resp_err,
    output logic          busy,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_byte
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [7:0]  mem [DEPTH_BYTES];

    logic [1:0]  state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic        wr_reg;
    logic [63:0] addr_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [63:0] wdata_reg;
    logic [63:0] rdata_reg;
    logic        err_reg;

    logic        src_write;
    logic [63:0] src_addr;
    logic [1:0]  src_size;
    logic        src_uns;
    logic [63:0] src_wdata;
    logic        commit;
    logic [3:0]  size_bytes;
    logic [2:0]  lane_mask;
    logic [64:0] end_addr;
    logic        acc_err;
    logic [63:0] raw_data;
    logic [63:0] ext_data;
    logic [DEPTH_BYTES-1:0]   byte_we;
    logic [8*DEPTH_BYTES-1:0] byte_wd;

    assign req_ready  = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign resp_valid = (state_reg == S_RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign dbg_byte   = mem[dbg_addr];

    // With zero wait states the access commits on the acceptance edge, so it must
    // be decoded straight from the request bus rather than from the latched copy.
    always_comb begin
        src_write = req_write;
        src_addr  = req_addr;
        src_size  = req_size;
        src_uns   = req_unsigned;
        src_wdata = req_wdata;
        if (state_reg != S_IDLE) begin
            src_write = wr_reg;
            src_addr  = addr_reg;
            src_size  = size_reg;
            src_uns   = uns_reg;
            src_wdata = wdata_reg;
        end
    end

    assign commit = ((state_reg == S_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                    ((state_reg == S_WAIT) && (cnt_reg == 4'd0));

    assign size_bytes = 4'd1 << src_size;
    assign lane_mask  = 3'(size_bytes - 4'd1);
    assign end_addr   = {1'b0, src_addr} + {61'd0, size_bytes};
    assign acc_err    = (|(src_addr[2:0] & lane_mask)) || (end_addr > 65'(DEPTH_BYTES));

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rd
            assign raw_data[8*gi +: 8] = mem[src_addr[AW-1:0] + AW'(gi)];
        end
        // The offset is one bit wider than the address so bytes below the access
        // base go negative instead of wrapping into the lane range.
        for (gi = 0; gi < DEPTH_BYTES; gi++) begin : g_wr
            logic [AW:0] off;
            assign off = (AW+1)'(gi) - {1'b0, src_addr[AW-1:0]};
            assign byte_we[gi] = commit && src_write && !acc_err &&
                                 (off < (AW+1)'(size_bytes));
            assign byte_wd[8*gi +: 8] = src_wdata[8*off[2:0] +: 8];
        end
    endgenerate

    always_comb begin
        ext_data = raw_data;
        case (src_size)
            2'b00:   ext_data = {{56{raw_data[7]  & ~src_uns}}, raw_data[7:0]};
            2'b01:   ext_data = {{48{raw_data[15] & ~src_uns}}, raw_data[15:0]};
            2'b10:   ext_data = {{32{raw_data[31] & ~src_uns}}, raw_data[31:0]};
            default: ext_data = raw_data;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req_valid) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_reg == 4'd0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
        end else begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                if (byte_we[i]) mem[i] <= byte_wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            wr_reg    <= 1'b0;
            addr_reg  <= 64'd0;
            size_reg  <= 2'd0;
            uns_reg   <= 1'b0;
            wdata_reg <= 64'd0;
            rdata_reg <= 64'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_IDLE) && req_valid) begin
                wr_reg    <= req_write;
                addr_reg  <= req_addr;
                size_reg  <= req_size;
                uns_reg   <= req_unsigned;
                wdata_reg <= req_wdata;
                cnt_reg   <= WS_INIT;
            end else if ((state_reg == S_WAIT) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (commit) begin
                err_reg <= acc_err;
                if (acc_err)
                    rdata_reg <= 64'd0;
                else if (!src_write)
                    rdata_reg <= ext_data;
            end
        end
    end

endmodule
